// File: rtl/simt_reg_file.sv
// simt_reg_file: per-lane banked register file for the SIMT core.
// Each lane holds NUM_REGS-3 general registers plus three read-only
// specials (block_dim, block_idx, lane id). Reads are registered with one
// cycle of latency. A sequential clear walks the general registers after
// reset and on every block launch.
// Optional build macro: RF_BYPASS_EN forwards same-cycle write data to reads
// of the address being written, for the lanes named by wmask.
module simt_reg_file #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned NUM_THREADS = 4,
  localparam int unsigned AW         = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          launch,
  input  logic [DATA_W-1:0]             block_idx,
  input  logic [DATA_W-1:0]             block_dim,
  output logic                          ready,
  input  logic                          rd_en,
  input  logic [AW-1:0]                 ra1,
  input  logic [AW-1:0]                 ra2,
  output logic [NUM_THREADS*DATA_W-1:0] rs1,
  output logic [NUM_THREADS*DATA_W-1:0] rs2,
  output logic                          rd_valid,
  input  logic                          we,
  input  logic [AW-1:0]                 wa,
  input  logic [NUM_THREADS*DATA_W-1:0] wd,
  input  logic [NUM_THREADS-1:0]        wmask,
  output logic                          wr_err
);

  localparam int unsigned NUM_GEN  = NUM_REGS - 3;
  localparam int unsigned LW       = NUM_THREADS * DATA_W;
  localparam logic [AW-1:0] GEN_LAST = AW'(NUM_GEN - 1);
  localparam logic [AW-1:0] ADDR_DIM = AW'(NUM_REGS - 3);
  localparam logic [AW-1:0] ADDR_IDX = AW'(NUM_REGS - 2);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state;
  logic [AW-1:0]     clr_ptr;
  logic [DATA_W-1:0] blk_dim_q;
  logic [DATA_W-1:0] blk_idx_q;

  logic          rd_ok_c;
  logic          wr_ok_c;
  logic          wr_drop_c;
  logic [LW-1:0] rd1_c;
  logic [LW-1:0] rd2_c;

  // A write commits only when idle, not launching, and aimed at a general reg.
  assign rd_ok_c   = rd_en && ready;
  assign wr_ok_c   = we && ready && !launch && (wa <= GEN_LAST);
  assign wr_drop_c = we && !wr_ok_c;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    logic [DATA_W-1:0] mem [NUM_GEN];
    logic [DATA_W-1:0] wd_l;
    logic [DATA_W-1:0] rd1_l;
    logic [DATA_W-1:0] rd2_l;

    assign wd_l = wd[t*DATA_W +: DATA_W];

    function automatic logic [DATA_W-1:0] word_at(input logic [AW-1:0] a);
      if (a <= GEN_LAST)     word_at = mem[a];
      else if (a == ADDR_DIM) word_at = blk_dim_q;
      else if (a == ADDR_IDX) word_at = blk_idx_q;
      else                    word_at = DATA_W'(t);
    endfunction

    // Clear walk takes priority; writes are only accepted when idle anyway.
    always_ff @(posedge clk) begin
      if (state == ST_CLEAR)           mem[clr_ptr] <= '0;
      else if (wr_ok_c && wmask[t])    mem[wa]      <= wd_l;
    end

    // Lane read mux, with optional forwarding of the in-flight write.
    always_comb begin
      rd1_l = word_at(ra1);
      rd2_l = word_at(ra2);
`ifdef RF_BYPASS_EN
      if (wr_ok_c && wmask[t] && (wa == ra1)) rd1_l = wd_l;
      if (wr_ok_c && wmask[t] && (wa == ra2)) rd2_l = wd_l;
`endif
    end

    assign rd1_c[t*DATA_W +: DATA_W] = rd1_l;
    assign rd2_c[t*DATA_W +: DATA_W] = rd2_l;
  end

  // Clear/ready FSM; launch relatches specials and restarts the clear walk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      ready     <= 1'b0;
      blk_dim_q <= '0;
      blk_idx_q <= '0;
    end else if (launch) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      ready     <= 1'b0;
      blk_dim_q <= block_dim;
      blk_idx_q <= block_idx;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == GEN_LAST) begin
            state <= ST_READY;
            ready <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + AW'(1);
          end
        end
        ST_READY: ready <= 1'b1;
        default: begin
          state <= ST_CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Registered read data, read-valid strobe and dropped-write pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1      <= '0;
      rs2      <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok_c;
      wr_err   <= wr_drop_c;
      if (rd_ok_c) begin
        rs1 <= rd1_c;
        rs2 <= rd2_c;
      end
    end
  end

endmodule

// File: tb/tb_simt_reg_file.sv
// Directed bench for simt_reg_file (default 16-bit, 16 regs, 4 lanes).
module tb_simt_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        launch;
  logic [15:0] block_idx;
  logic [15:0] block_dim;
  logic        ready;
  logic        rd_en;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        rd_valid;
  logic        we;
  logic [3:0]  wa;
  logic [63:0] wd;
  logic [3:0]  wmask;
  logic        wr_err;

  int n_cmp  = 0;
  int n_fail = 0;

  simt_reg_file dut (
    .clk(clk), .reset(reset), .launch(launch),
    .block_idx(block_idx), .block_dim(block_dim), .ready(ready),
    .rd_en(rd_en), .ra1(ra1), .ra2(ra2), .rs1(rs1), .rs2(rs2),
    .rd_valid(rd_valid), .we(we), .wa(wa), .wd(wd), .wmask(wmask),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a1, input logic [3:0] a2);
    rd_en = 1'b1; ra1 = a1; ra2 = a2;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    tick(); tick();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    n_cmp++; if (rs1 !== 64'h0) begin n_fail++; $display("FAIL reset_rs1: got %h want 0", rs1); end
    n_cmp++; if (rs2 !== 64'h0) begin n_fail++; $display("FAIL reset_rs2: got %h want 0", rs2); end
  endtask

  task automatic test_launch_clear;
    int n;
    reset = 1'b0;
    launch = 1'b1; block_idx = 16'd5; block_dim = 16'd8;
    tick();
    launch = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL launch_ready_low: got %b want 0", ready); end
    n = 0;
    while (n < 40 && ready !== 1'b1) begin tick(); n++; end
    n_cmp++; if (n !== 13) begin n_fail++; $display("FAIL launch_clear_cycles: got %0d want 13", n); end
    do_read(4'd13, 4'd14);
    n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL spec_rd_valid: got %b want 1", rd_valid); end
    for (int t = 0; t < 4; t++) begin
      n_cmp++; if (rs1[t*16 +: 16] !== 16'd8) begin n_fail++; $display("FAIL spec_dim lane%0d: got %h want 0008", t, rs1[t*16 +: 16]); end
      n_cmp++; if (rs2[t*16 +: 16] !== 16'd5) begin n_fail++; $display("FAIL spec_idx lane%0d: got %h want 0005", t, rs2[t*16 +: 16]); end
    end
    do_read(4'd15, 4'd0);
    for (int t = 0; t < 4; t++) begin
      n_cmp++; if (rs1[t*16 +: 16] !== 16'(t)) begin n_fail++; $display("FAIL spec_tid lane%0d: got %h want %h", t, rs1[t*16 +: 16], 16'(t)); end
      n_cmp++; if (rs2[t*16 +: 16] !== 16'd0) begin n_fail++; $display("FAIL cleared_r0 lane%0d: got %h want 0000", t, rs2[t*16 +: 16]); end
    end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rs1 !== 64'h0003_0002_0001_0000) begin n_fail++; $display("FAIL rs1_hold: got %h want 0003000200010000", rs1); end
  endtask

  task automatic test_masked_write;
    we = 1'b1; wa = 4'd3; wd = {16'hD, 16'hC, 16'hB, 16'hA}; wmask = 4'b0101;
    tick();
    we = 1'b0;
    n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL mask_wr_err: got %b want 0", wr_err); end
    do_read(4'd3, 4'd3);
    n_cmp++; if (rs1 !== 64'h0000_000C_0000_000A) begin n_fail++; $display("FAIL masked_r3: got %h want 0000000c0000000a", rs1); end
    we = 1'b1; wa = 4'd4; wd = {4{16'hFFFF}}; wmask = 4'b0000;
    tick();
    we = 1'b0;
    n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL zero_mask_wr_err: got %b want 0", wr_err); end
    do_read(4'd4, 4'd3);
    n_cmp++; if (rs1 !== 64'h0) begin n_fail++; $display("FAIL zero_mask_r4: got %h want 0", rs1); end
  endtask

  task automatic test_bad_write;
    we = 1'b1; wa = 4'd14; wd = {4{16'h1111}}; wmask = 4'hF;
    tick();
    we = 1'b0;
    n_cmp++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL special_wr_err: got %b want 1", wr_err); end
    tick();
    n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
    do_read(4'd14, 4'd13);
    n_cmp++; if (rs1 !== {4{16'd5}}) begin n_fail++; $display("FAIL r14_unchanged: got %h want 0005 x4", rs1); end
    n_cmp++; if (rs2 !== {4{16'd8}}) begin n_fail++; $display("FAIL r13_unchanged: got %h want 0008 x4", rs2); end
  endtask

  task automatic test_bypass;
    logic [63:0] exp_rs1;
`ifdef RF_BYPASS_EN
    exp_rs1 = {4{16'h1234}};
`else
    exp_rs1 = 64'h0;
`endif
    rd_en = 1'b1; ra1 = 4'd7; ra2 = 4'd3;
    we = 1'b1; wa = 4'd7; wd = {4{16'h1234}}; wmask = 4'hF;
    tick();
    rd_en = 1'b0; we = 1'b0;
    n_cmp++; if (rs1 !== exp_rs1) begin n_fail++; $display("FAIL same_cycle_r7: got %h want %h", rs1, exp_rs1); end
    n_cmp++; if (rs2 !== 64'h0000_000C_0000_000A) begin n_fail++; $display("FAIL same_cycle_r3: got %h want 0000000c0000000a", rs2); end
    do_read(4'd7, 4'd7);
    n_cmp++; if (rs1 !== {4{16'h1234}}) begin n_fail++; $display("FAIL r7_committed: got %h want 1234 x4", rs1); end
  endtask

  task automatic test_relaunch;
    int n;
    we = 1'b1; wa = 4'd2; wd = {4{16'h00FF}}; wmask = 4'hF;
    tick();
    we = 1'b0;
    do_read(4'd2, 4'd2);
    n_cmp++; if (rs1 !== {4{16'h00FF}}) begin n_fail++; $display("FAIL r2_written: got %h want 00ff x4", rs1); end
    launch = 1'b1; block_idx = 16'd9; block_dim = 16'd8;
    we = 1'b1; wa = 4'd2; wd = {4{16'hAAAA}}; wmask = 4'hF;
    tick();
    launch = 1'b0;
    n_cmp++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL launch_we_wr_err: got %b want 1", wr_err); end
    wa = 4'd5; wd = {4{16'hBEEF}}; rd_en = 1'b1; ra1 = 4'd13;
    n = 0;
    while (n < 40 && ready !== 1'b1) begin
      tick(); n++;
      if (n == 1) begin
        n_cmp++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL busy_wr_err: got %b want 1", wr_err); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL busy_rd_valid: got %b want 0", rd_valid); end
        we = 1'b0; rd_en = 1'b0;
      end
    end
    n_cmp++; if (n !== 13) begin n_fail++; $display("FAIL relaunch_clear_cycles: got %0d want 13", n); end
    do_read(4'd2, 4'd14);
    n_cmp++; if (rs1 !== 64'h0) begin n_fail++; $display("FAIL r2_recleared: got %h want 0", rs1); end
    n_cmp++; if (rs2 !== {4{16'd9}}) begin n_fail++; $display("FAIL r14_relatched: got %h want 0009 x4", rs2); end
    do_read(4'd5, 4'd13);
    n_cmp++; if (rs1 !== 64'h0) begin n_fail++; $display("FAIL busy_write_dropped: got %h want 0", rs1); end
    n_cmp++; if (rs2 !== {4{16'd8}}) begin n_fail++; $display("FAIL r13_relatched: got %h want 0008 x4", rs2); end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    launch = 1'b1; block_idx = 16'd3; block_dim = 16'd4;
    rd_en = 1'b1; ra1 = 4'd14; ra2 = 4'd13;
    tick();
    launch = 1'b0; rd_en = 1'b0;
    n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL launch_rd_valid: got %b want 1", rd_valid); end
    n_cmp++; if (rs1 !== {4{16'd9}}) begin n_fail++; $display("FAIL launch_rd_old_idx: got %h want 0009 x4", rs1); end
    n_cmp++; if (rs2 !== {4{16'd8}}) begin n_fail++; $display("FAIL launch_rd_old_dim: got %h want 0008 x4", rs2); end
    repeat (6) tick();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_clear_ready: got %b want 0", ready); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b want 0", ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rs1 !== 64'h0) begin n_fail++; $display("FAIL async_reset_rs1: got %h want 0", rs1); end
    tick();
    reset = 1'b0;
    n = 0;
    while (n < 40 && ready !== 1'b1) begin tick(); n++; end
    n_cmp++; if (n !== 13) begin n_fail++; $display("FAIL reset_clear_cycles: got %0d want 13", n); end
    do_read(4'd14, 4'd13);
    n_cmp++; if (rs1 !== 64'h0) begin n_fail++; $display("FAIL reset_r14: got %h want 0", rs1); end
    n_cmp++; if (rs2 !== 64'h0) begin n_fail++; $display("FAIL reset_r13: got %h want 0", rs2); end
    do_read(4'd7, 4'd15);
    n_cmp++; if (rs1 !== 64'h0) begin n_fail++; $display("FAIL reset_r7_cleared: got %h want 0", rs1); end
    n_cmp++; if (rs2 !== 64'h0003_0002_0001_0000) begin n_fail++; $display("FAIL reset_r15: got %h want 0003000200010000", rs2); end
  endtask

  initial begin
    reset = 1'b1; launch = 1'b0; block_idx = '0; block_dim = '0;
    rd_en = 1'b0; ra1 = '0; ra2 = '0;
    we = 1'b0; wa = '0; wd = '0; wmask = '0;
    test_reset();
    test_launch_clear();
    test_masked_write();
    test_bad_write();
    test_bypass();
    test_relaunch();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
